// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-read FIFO onto a valid/ready
// stream through a 2-entry output buffer.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  err_underflow
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t                  occ;
   logic                  rd_pend;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] tail;
   logic                  pop;
   logic [2:0]            used;

   assign pop = m_valid && m_ready;

   // Buffered plus in-flight words, net of the word leaving this cycle.
   assign used = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};

   assign fifo_rd_en = rst_n && enable && !fifo_empty && (used < 3'd2);
   assign m_data     = head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ           <= EMPTY;
         m_valid       <= 1'b0;
         rd_pend       <= 1'b0;
         head          <= '0;
         tail          <= '0;
         word_count    <= '0;
         err_underflow <= 1'b0;
      end else begin
         rd_pend <= fifo_rd_en;
         if (pop)
            word_count <= word_count + CNT_WIDTH'(1);
         if (fifo_underflow)
            err_underflow <= 1'b1;
         unique case (occ)
            EMPTY: begin
               if (rd_pend) begin
                  head    <= fifo_data_out;
                  occ     <= ONE;
                  m_valid <= 1'b1;
               end
            end
            ONE: begin
               unique case ({rd_pend, pop})
                  2'b11: head <= fifo_data_out;
                  2'b10: begin
                     tail <= fifo_data_out;
                     occ  <= TWO;
                  end
                  2'b01: begin
                     occ     <= EMPTY;
                     m_valid <= 1'b0;
                  end
                  default: ;
               endcase
            end
            TWO: begin
               if (pop) begin
                  head <= tail;
                  if (rd_pend)
                     tail <= fifo_data_out;
                  else
                     occ <= ONE;
               end
            end
            default: begin
               occ     <= EMPTY;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

   // The read credit rule must never let a word arrive into a full buffer.
   no_overrun: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(rd_pend && occ == TWO && !pop)
   );

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side master for the team's synchronous FIFO. It drains the FIFO through its `rd_en`/`data_out` port and presents the words on a valid/ready stream. It hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer, so downstream logic sees a plain handshake at up to one word per clock. It sits between the FIFO and any consumer that can apply backpressure.

## Interface
- `DATA_WIDTH`, default 16: width of FIFO words and stream data.
- `CNT_WIDTH`, default 16: width of the accepted-word counter.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new FIFO reads when high.
- `fifo_rd_en`  out  1  FIFO read strobe; combinational.
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data; valid the cycle after a successful read.
- `fifo_empty`  in  1  FIFO empty flag (count==0).
- `fifo_underflow`  in  1  FIFO underflow flag.
- `m_valid`  out  1  output word available.
- `m_data`  out  DATA_WIDTH  output word.
- `m_ready`  in  1  consumer accepts the word when high together with `m_valid`.
- `word_count`  out  CNT_WIDTH  number of accepted output beats; wraps modulo 2^CNT_WIDTH.
- `err_underflow`  out  1  sticky; set if `fifo_underflow` is ever seen high.

## Operation
- State:
  - `occ` is the buffer occupancy, one of EMPTY (0), ONE (1) or TWO (2).
  - `rd_pend` is 1 in the cycle after `fifo_rd_en` was high; the FIFO word arrives that cycle.
  - The buffer is a 2-entry FIFO of registers: head and tail.
- `pop` = `m_valid && m_ready`.
- `fifo_rd_en` = `rst_n && enable && !fifo_empty && (occ + rd_pend - pop) < 2`.
  - `fifo_empty` is accurate each cycle, so `fifo_rd_en` never causes a FIFO underflow.
- Capture: when `rd_pend`, `fifo_data_out` is written into the buffer at the clock edge.
  - Written to head if the buffer is empty after `pop`, otherwise to tail.
- Pop: when `pop`, tail moves to head and `occ` decrements.
  - Pop and capture in the same cycle leave `occ` unchanged.
- State transitions (c = `rd_pend`, p = `pop`):
  - EMPTY→ONE on c.
  - ONE→TWO on c&!p.
  - ONE→EMPTY on p&!c.
  - TWO→ONE on p.
  - The credit rule makes c with `occ`==2 and !p impossible; assert on it.
- `m_valid` = (`occ` != 0). `m_data` = head.
- `m_data` is held stable while `m_valid && !m_ready`. Valid-before-ready is allowed; `m_valid` never drops without a pop.
- `enable` low blocks new reads only:
  - an in-flight word is still captured;
  - buffered words are still presented.
- `word_count` increments by 1 on each `pop`.
- `err_underflow` sets on `fifo_underflow` and clears only on reset.

## Timing
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `word_count` = 0, `err_underflow` = 0;
  - `occ` = EMPTY, `rd_pend` = 0;
  - `fifo_rd_en` = 0 while `rst_n` is low.
- Latency: `fifo_rd_en` high in cycle T, word on `fifo_data_out` in T+1, `m_valid` high in T+2.
- Throughput: 1 word/clock sustained with `m_ready` held high.
  - Steady state is `occ`=1, `rd_pend`=1, `pop`=1, with a read issued every cycle.
- Backpressure: at most 2 words are outstanding (buffered plus in flight). `fifo_rd_en` stays 0 until a pop frees credit.
- `m_ready` feeds `fifo_rd_en` combinationally. There is no path from `m_ready` to `m_valid` or `m_data`.
- Reset asserted mid-stream:
  - buffered and in-flight words are discarded;
  - outputs return to reset values immediately;
  - the FIFO is reset by the same `rst_n`.
- The FIFO's `count` is not visible to this block; `fifo_empty` is the only flow control.

## Test plan
- Single word: FIFO holds 0xA5A5, `enable`=1, `m_ready`=1.
  - `fifo_rd_en` is high for 1 cycle.
  - 2 cycles later `m_valid`=1 with `m_data`=0xA5A5 for exactly 1 cycle; `word_count`=1.
- Burst: 8 words 0x0001..0x0008 in the FIFO, `m_ready`=1.
  - `fifo_rd_en` is high for 8 consecutive cycles.
  - `m_valid` is high for 8 consecutive cycles in order; `word_count`=8; `err_underflow`=0.
- Backpressure: 8 words, `m_ready`=0 for 10 cycles, then 1.
  - Exactly 2 reads are issued, then `fifo_rd_en` stays 0.
  - `m_data`=0x0001 is held stable.
  - After release, all 8 words arrive in order with no loss or duplication.
- Enable gating: `enable` drops the cycle after the 3rd `fifo_rd_en`.
  - Exactly 3 words are delivered and no further reads are issued.
  - Re-enabling resumes with word 4.
- Reset mid-stream: `rst_n` low while `occ`=TWO.
  - `m_valid`=0 and `word_count`=0 immediately.
  - After release with the FIFO refilled by 0x00FF, only 0x00FF is delivered.
- Underflow flag: force `fifo_underflow`=1 for one cycle.
  - `err_underflow`=1 and stays set until reset; the stream is otherwise unaffected.
